// File: rtl/req_issuer.sv
// req_issuer: holds req for HOLD cycles, then waits for an asynchronous fin strobe and pulses done.
// Define REQ_ISSUER_TIMEOUT_EN to add the 8-bit wait counter that aborts with a timeout pulse.
module req_issuer #(
  parameter int unsigned HOLD    = 2,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic start_i,
  output logic busy_o,
  output logic req_o,
  input  logic fin_i,
  output logic done_o,
  output logic timeout_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic       pend_q, pend_d;
  logic       tmo_q, tmo_d;
  logic       req_q;
  logic       sync1_q, sync2_q, last_q;
  logic       fin_evt;
  logic       last_hold;
  logic       expire;

  // Toggle capture survives rst_n so a fin racing a reset is never lost, only classified as stray.
  logic fin_tgl_q = 1'b0;

  always_ff @(posedge fin_i) begin
    fin_tgl_q <= ~fin_tgl_q;
  end

  // last_q follows the synchronizer every cycle, including during reset, so an event is a one-cycle pulse.
  always_ff @(posedge clk_i) begin
    sync1_q <= fin_tgl_q;
    sync2_q <= sync1_q;
    last_q  <= sync2_q;
  end

  assign fin_evt   = sync2_q ^ last_q;
  assign last_hold = (hold_q == 4'(HOLD));

`ifdef REQ_ISSUER_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && start_i) begin
      cnt_d = 8'd0;
    end else if ((state_q == ASSERT || state_q == WAIT) && cnt_q != 8'hff) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expires on the edge where the counter would reach TIMEOUT.
  assign expire = (state_q == ASSERT || state_q == WAIT) &&
                  (({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT;
  assign expire     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pend_d  = pend_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ASSERT;
          hold_d  = 4'd1;
          pend_d  = 1'b0;
        end
      end
      ASSERT: begin
        hold_d = hold_q + 4'd1;
        if (fin_evt) begin
          pend_d = 1'b1;
        end
        if ((fin_evt || pend_q) && (last_hold || expire)) begin
          state_d = FINISH;
        end else if (expire) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else if (last_hold) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (fin_evt) begin
          state_d = FINISH;
        end else if (expire) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      hold_q  <= 4'd0;
      pend_q  <= 1'b0;
      tmo_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
      req_q   <= (state_d == ASSERT);
    end
  end

  assign req_o     = req_q;
  assign busy_o    = (state_q == ASSERT) || (state_q == WAIT);
  assign done_o    = (state_q == FINISH);
  assign timeout_o = tmo_q;

endmodule
